// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter that serves
// the IF and MEM stages of the pipeline.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory request/response channel: valid/ready request,
// rvalid response (read data or write acknowledge).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_strb;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_valid, m_we, m_addr, m_wdata, m_strb,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_valid, m_we, m_addr, m_wdata, m_strb,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == W'(MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port; data wins
// unless fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_strb,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  mem_arbiter_if.master     mem
);
  arb_state_t        state;
  arb_owner_t        owner;
  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic              kill;
  logic              kill_now;
  logic              at_max;
  logic              grant_d;
  logic              grant_i;

  assign grant_d  = (state == ST_IDLE) && d_req && (!at_max || !if_req);
  assign grant_i  = (state == ST_IDLE) && !grant_d && if_req && !if_flush;
  // A flush in the same cycle as the response must still suppress the fetch.
  assign kill_now = kill || (if_flush && owner == OWN_I);

  mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (aclk),
    .rst    (areset),
    .inc    (grant_d && if_req),
    .clr    (grant_i || !if_req),
    .at_max (at_max)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      kill     <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          kill <= 1'b0;
          if (grant_d) begin
            owner   <= OWN_D;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            strb_q  <= d_strb;
            valid_q <= 1'b1;
            state   <= ST_ISSUE;
          end else if (grant_i) begin
            owner   <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            strb_q  <= '0;
            valid_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (kill_now) kill <= 1'b1;
          if (mem.m_ready) begin
            valid_q <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (kill_now) kill <= 1'b1;
          if (mem.m_rvalid) begin
            state <= ST_DONE;
            if (owner == OWN_I && !kill_now) begin
              if_done  <= 1'b1;
              if_rdata <= mem.m_rdata;
            end
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              if (!we_q) d_rdata <= mem.m_rdata;
            end
          end
        end
        ST_DONE: begin
          owner <= OWN_NONE;
          kill  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.m_valid = valid_q;
  assign mem.m_we    = we_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_wdata = wdata_q;
  assign mem.m_strb  = strb_q;
endmodule
